// File: rtl/sram_like_responder.sv
`default_nettype none
// ==========================================================================
// sram_like_responder: addr_ok/data_ok memory responder, word array, rev 1.0
// ==========================================================================
module sram_like_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int       DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    wr_q;
  logic [1:0]              size_q;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be;
  logic [ADDR_WIDTH-1:0]   idx_in;
  logic                    unused_addr_hi;
  logic [31:0]             mem [0:DEPTH-1];

  assign idx_in         = addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];
  assign addr_ok        = (state == IDLE);

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << off_q;
      2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      data_ok <= 1'b0;
      rdata   <= 32'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size;
            off_q   <= addr[1:0];
            idx_q   <= idx_in;
            wdata_q <= wdata;
            cnt     <= LAT;
            if (LAT == 4'd0) begin
              // zero latency: respond in the very next cycle from the live inputs
              state   <= RESP;
              data_ok <= 1'b1;
              if (!wr) rdata <= mem[idx_in];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            data_ok <= 1'b1;
            if (!wr_q) rdata <= mem[idx_q];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write commits at the end of RESP; a reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (resetn && (state == RESP) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// ==========================================================================
// tb_sram_like_responder: directed + randomized checks against a word model
// ==========================================================================
module tb_sram_like_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        req_z, wr_z;
  logic [1:0]  size_z;
  logic [31:0] addr_z, wdata_z;
  logic        addr_ok_z, data_ok_z;
  logic [31:0] rdata_z;

  int cmp  = 0;
  int errs = 0;
  logic [31:0] model   [0:(1<<AW)-1];
  logic [31:0] model_z [0:(1<<AW)-1];

  always #5 clk = ~clk;

  sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));

  sram_like_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dut_z (
    .clk(clk), .resetn(resetn), .req(req_z), .wr(wr_z), .size(size_z), .addr(addr_z),
    .wdata(wdata_z), .addr_ok(addr_ok_z), .data_ok(data_ok_z), .rdata(rdata_z));

  // Merge a lane-positioned write into an old word following the size/offset rules.
  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0: r[8*a[1:0] +: 8] = wd[8*a[1:0] +: 8];
      2'd1: if (a[1]) r[31:16] = wd[31:16]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // One transaction on the LATENCY=2 instance; returns observations only.
  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int lat,
                     output int ao_bad);
    bit got;
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (addr_ok === 1'b1) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    lat = -1; ao_bad = 0; rd = 'x;
    if (got) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (addr_ok !== 1'b0) ao_bad++;
        if (data_ok === 1'b1) begin lat = k; rd = rdata; break; end
      end
    end
  endtask

  task automatic test_reset();
    int k_ok;
    resetn = 1'b0; req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0; wdata = 32'h0;
    req_z = 1'b0; wr_z = 1'b0; size_z = 2'd0; addr_z = 32'h0; wdata_z = 32'h0;
    repeat (3) begin
      @(negedge clk);
      cmp++;
      if (addr_ok !== 1'b1 || data_ok !== 1'b0 || rdata !== 32'h0) begin
        errs++;
        $display("FAIL reset_state: addr_ok=%b data_ok=%b rdata=%h, want 1 0 00000000",
                 addr_ok, data_ok, rdata);
      end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp++;
    if (addr_ok !== 1'b0) begin
      errs++;
      $display("FAIL reset_release_accept: addr_ok=%b after first edge, want 0", addr_ok);
    end
    req = 1'b0;
    k_ok = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (data_ok === 1'b1) begin k_ok = k; break; end
    end
    cmp++;
    if (k_ok != LAT + 1) begin
      errs++;
      $display("FAIL reset_first_latency: data_ok at %0d, want %0d", k_ok, LAT + 1);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; int lat, aob;
    txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat, aob);
    cmp++;
    if (lat != LAT + 1 || aob != 0) begin
      errs++;
      $display("FAIL word_write_timing: lat=%0d addr_ok_high=%0d, want %0d 0", lat, aob, LAT + 1);
    end
    @(negedge clk);
    cmp++;
    if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin
      errs++;
      $display("FAIL data_ok_pulse: data_ok=%b addr_ok=%b after RESP, want 0 1", data_ok, addr_ok);
    end
    txn(1'b0, 2'd2, 32'h10, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'hDEADBEEF || lat != LAT + 1) begin
      errs++;
      $display("FAIL word_read: rdata=%h lat=%0d, want deadbeef %0d", rd, lat, LAT + 1);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; int lat, aob;
    txn(1'b1, 2'd2, 32'h20, 32'h11223344, rd, lat, aob);
    txn(1'b1, 2'd0, 32'h21, 32'h0000AA00, rd, lat, aob);
    txn(1'b0, 2'd0, 32'h23, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'h1122AA44) begin
      errs++;
      $display("FAIL byte_lane: rdata=%h, want 1122aa44", rd);
    end
    txn(1'b1, 2'd1, 32'h23, 32'hBEEF0000, rd, lat, aob);
    cmp++;
    if (rd !== 32'h1122AA44) begin
      errs++;
      $display("FAIL rdata_hold_on_write: rdata=%h, want 1122aa44", rd);
    end
    txn(1'b0, 2'd1, 32'h20, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'hBEEFAA44) begin
      errs++;
      $display("FAIL halfword_lane: rdata=%h, want beefaa44", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat, aob;
    txn(1'b1, 2'd2, 32'h00001004, 32'hA5A50F0F, rd, lat, aob);
    txn(1'b0, 2'd2, 32'h00000004, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'hA5A50F0F) begin
      errs++;
      $display("FAIL addr_wrap: rdata=%h, want a5a50f0f", rd);
    end
    txn(1'b1, 2'd2, 32'h33, 32'hCAFEF00D, rd, lat, aob);
    txn(1'b0, 2'd0, 32'h30, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'hCAFEF00D) begin
      errs++;
      $display("FAIL misaligned_word: rdata=%h, want cafef00d", rd);
    end
    txn(1'b1, 2'd3, 32'h35, 32'h01020304, rd, lat, aob);
    txn(1'b0, 2'd2, 32'h34, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'h01020304) begin
      errs++;
      $display("FAIL size3_word: rdata=%h, want 01020304", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat, aob, seen;
    txn(1'b1, 2'd2, 32'h40, 32'h12345678, rd, lat, aob);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'h55555555;
    @(posedge clk); #1;
    req = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    cmp++;
    if (addr_ok !== 1'b1 || rdata !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid_state: addr_ok=%b rdata=%h, want 1 00000000", addr_ok, rdata);
    end
    seen = (data_ok === 1'b1) ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (data_ok === 1'b1) seen++;
    end
    cmp++;
    if (seen != 0) begin
      errs++;
      $display("FAIL reset_mid_no_data_ok: data_ok pulses=%0d, want 0", seen);
    end
    txn(1'b0, 2'd2, 32'h40, 32'h0, rd, lat, aob);
    cmp++;
    if (rd !== 32'h12345678) begin
      errs++;
      $display("FAIL reset_mid_no_commit: rdata=%h, want 12345678", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp, last_rd; int lat, aob; logic w; logic [1:0] sz; int idx;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      txn(1'b1, 2'd2, 32'(i) << 2, d, rd, lat, aob);
      model[i] = d;
    end
    last_rd = 32'h12345678;
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 7);
      a   = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      exp = w ? last_rd : model[idx];
      txn(w, sz, a, d, rd, lat, aob);
      if (w) model[idx] = apply_write(model[idx], d, sz, a);
      else last_rd = model[idx];
      cmp++;
      if (rd !== exp || lat != LAT + 1 || aob != 0) begin
        errs++;
        $display("FAIL random_txn[%0d] wr=%b addr=%h: rdata=%h lat=%0d ao=%0d, want %h %0d 0",
                 i, w, a, rd, lat, aob, exp, LAT + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, exp, last_rd; logic w; logic [1:0] sz; int idx;
    last_rd = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        w = 1'b1; sz = 2'd2; idx = i; a = 32'(i) << 2;
      end else begin
        w = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
        idx = $urandom_range(0, 3); a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      end
      d = $urandom;
      req_z = 1'b1; wr_z = w; size_z = sz; addr_z = a; wdata_z = d;
      exp = w ? last_rd : model_z[idx];
      @(negedge clk);
      cmp++;
      if (addr_ok_z !== 1'b1 || data_ok_z !== 1'b0) begin
        errs++;
        $display("FAIL b2b_idle[%0d]: addr_ok=%b data_ok=%b, want 1 0", i, addr_ok_z, data_ok_z);
      end
      @(posedge clk); #1;
      wr_z = 1'b1; size_z = 2'd2; addr_z = 32'h800 | ($urandom & 32'hFC); wdata_z = $urandom;
      @(negedge clk);
      cmp++;
      if (addr_ok_z !== 1'b0 || data_ok_z !== 1'b1 || rdata_z !== exp) begin
        errs++;
        $display("FAIL b2b_resp[%0d]: addr_ok=%b data_ok=%b rdata=%h, want 0 1 %h",
                 i, addr_ok_z, data_ok_z, rdata_z, exp);
      end
      if (w) model_z[idx] = apply_write(model_z[idx], d, sz, a);
      else last_rd = model_z[idx];
      @(posedge clk); #1;
    end
    req_z = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
